// File: rtl/demux_dispatch_1to8_if.sv
// rtl/demux_dispatch_1to8_if.sv - stream-in / eight-lane stream-out bundle for the 1-to-8 dispatcher
interface demux_dispatch_1to8_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [2:0]        in_sel;
    logic [7:0]        out_valid;
    logic [7:0]        out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        cur_sel;
    logic [CNT_W-1:0]  sent_count;

    modport master (
        output mode, in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, cur_sel, sent_count
    );

    modport slave (
        input  mode, in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, cur_sel, sent_count
    );
endinterface

// File: rtl/demux_dispatch_1to8.sv
// rtl/demux_dispatch_1to8.sv - registered 1-to-8 dispatcher with one-entry holding stage
module demux_dispatch_1to8 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_dispatch_1to8_if.slave  bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        state;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        sel_q;
    logic [2:0]        rr_ptr;
    logic [CNT_W-1:0]  count_q;

    logic              lane_ready;
    logic              in_ready;
    logic              accept;
    logic              xfer;
    logic [2:0]        tgt;

    // Ready is combinational from the held lane so a drain and a refill share one cycle.
    always_comb begin
        lane_ready = bus.out_ready[sel_q];
        xfer       = (state == ST_HOLD) && lane_ready;
        in_ready   = (state == ST_IDLE) || xfer;
        accept     = bus.in_valid && in_ready;
        tgt        = bus.mode ? rr_ptr : bus.in_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            rr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                state  <= ST_HOLD;
                data_q <= bus.in_data;
                sel_q  <= tgt;
                if (bus.mode) begin
                    rr_ptr <= rr_ptr + 3'd1;
                end
            end else if (xfer) begin
                state <= ST_IDLE;
            end

            if (xfer && !(&count_q)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.out_valid  = (state == ST_HOLD) ? (8'd1 << sel_q) : 8'd0;
        bus.out_data   = data_q;
        bus.cur_sel    = sel_q;
        bus.in_ready   = in_ready;
        bus.sent_count = count_q;
    end
endmodule

// File: tb/tb_demux_dispatch_1to8.sv
// tb/tb_demux_dispatch_1to8.sv - directed and randomized check of demux_dispatch_1to8 against a queue model
module tb_demux_dispatch_1to8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    demux_dispatch_1to8_if #(.DATA_W(8), .CNT_W(16)) bus ();

    demux_dispatch_1to8 #(.DATA_W(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] lane;
    } word_t;

    word_t q[$];
    int    m_rr = 0;
    int    m_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: words waiting to leave, in order; the DUT may hold at most one.
    always @(negedge clk) begin
        logic [7:0] exp_valid;
        logic       exp_ready;
        if (!rst_n) begin
            q.delete();
            m_rr = 0;
            m_count = 0;
            check("rst_out_valid", {24'd0, bus.out_valid}, 32'd0);
            check("rst_sent_count", {16'd0, bus.sent_count}, 32'd0);
        end else begin
            exp_valid = (q.size() != 0) ? (8'd1 << q[0].lane) : 8'd0;
            exp_ready = (q.size() == 0) || bus.out_ready[q[0].lane];
            check("m_out_valid", {24'd0, bus.out_valid}, {24'd0, exp_valid});
            if (q.size() != 0) begin
                check("m_out_data", {24'd0, bus.out_data}, {24'd0, q[0].data});
                check("m_cur_sel", {29'd0, bus.cur_sel}, {29'd0, q[0].lane});
            end
            check("m_in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
            check("m_sent_count", {16'd0, bus.sent_count}, m_count);
            if (q.size() != 0 && bus.out_ready[q[0].lane]) begin
                void'(q.pop_front());
                if (m_count < 65535) m_count++;
            end
            if (bus.in_valid && exp_ready) begin
                q.push_back({bus.in_data, bus.mode ? 3'(m_rr) : bus.in_sel});
                if (bus.mode) m_rr = (m_rr + 1) % 8;
            end
            check("m_depth", q.size(), (q.size() > 1) ? 32'd1 : q.size());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic v, input logic [7:0] d, input logic [2:0] s, input logic [7:0] r);
        bus.mode = m;
        bus.in_valid = v;
        bus.in_data = d;
        bus.in_sel = s;
        bus.out_ready = r;
    endtask

    task automatic do_reset();
        cyc();
        #2;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_async_valid", {24'd0, bus.out_valid}, 32'd0);
        check("rst_async_data", {24'd0, bus.out_data}, 32'd0);
        check("rst_async_sel", {29'd0, bus.cur_sel}, 32'd0);
        check("rst_async_count", {16'd0, bus.sent_count}, 32'd0);
        check("rst_async_ready", {31'd0, bus.in_ready}, 32'd1);
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        logic       modes [5];
        logic [2:0] sels  [5];
        logic [2:0] lanes [5];

        drive(1'b0, 1'b0, 8'h00, 3'd0, 8'hFF);
        #2;
        check("init_out_valid", {24'd0, bus.out_valid}, 32'd0);
        check("init_in_ready", {31'd0, bus.in_ready}, 32'd1);
        cyc();
        rst_n = 1'b1;

        // Addressed single word
        do_reset();
        cyc(); drive(1'b0, 1'b1, 8'hA5, 3'd5, 8'hFF);
        cyc(); bus.in_valid = 1'b0; #1;
        check("addr_valid", {24'd0, bus.out_valid}, 32'h20);
        check("addr_data", {24'd0, bus.out_data}, 32'hA5);
        check("addr_sel", {29'd0, bus.cur_sel}, 32'd5);
        cyc(); #1;
        check("addr_drain_valid", {24'd0, bus.out_valid}, 32'd0);
        check("addr_count", {16'd0, bus.sent_count}, 32'd1);

        // Backpressure on lane 5, other lanes ready (ignored)
        do_reset();
        cyc(); drive(1'b0, 1'b1, 8'hA5, 3'd5, 8'hDF);
        for (int k = 0; k < 3; k++) begin
            cyc(); bus.in_valid = (k == 0) ? 1'b0 : 1'b1; bus.in_data = 8'h77; #1;
            check("bp_valid", {24'd0, bus.out_valid}, 32'h20);
            check("bp_data", {24'd0, bus.out_data}, 32'hA5);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        cyc(); bus.in_valid = 1'b0; bus.out_ready = 8'hFF; #1;
        check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        cyc(); #1;
        check("bp_after_valid", {24'd0, bus.out_valid}, 32'd0);
        check("bp_after_count", {16'd0, bus.sent_count}, 32'd1);

        // Round-robin, nine back-to-back words
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc();
            drive(1'b1, (i < 9), 8'(8'h10 + i), 3'(7 - (i % 8)), 8'hFF);
            #1;
            if (i > 0) begin
                check("rr_valid", {24'd0, bus.out_valid}, 32'd1 << ((i - 1) % 8));
                check("rr_data", {24'd0, bus.out_data}, 32'h10 + i - 1);
            end
            check("rr_in_ready", {31'd0, bus.in_ready}, 32'd1);
        end
        cyc(); #1;
        check("rr_count", {16'd0, bus.sent_count}, 32'd9);

        // Mode switch keeps the round-robin pointer
        modes = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        sels  = '{3'd7, 3'd7, 3'd7, 3'd6, 3'd7};
        lanes = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(); drive(modes[i], 1'b1, 8'(8'h50 + i), sels[i], 8'hFF);
            cyc(); bus.in_valid = 1'b0; bus.mode = ~modes[i]; #1;
            check("ms_sel", {29'd0, bus.cur_sel}, {29'd0, lanes[i]});
            check("ms_valid", {24'd0, bus.out_valid}, 32'd1 << lanes[i]);
        end

        // Reset while a word is held
        do_reset();
        cyc(); drive(1'b0, 1'b1, 8'h3C, 3'd2, 8'hFB);
        cyc(); bus.in_valid = 1'b0; #1;
        check("rh_held", {24'd0, bus.out_valid}, 32'h04);
        #1; rst_n = 1'b0; #1;
        check("rh_async_valid", {24'd0, bus.out_valid}, 32'd0);
        check("rh_async_count", {16'd0, bus.sent_count}, 32'd0);
        cyc(); rst_n = 1'b1; bus.out_ready = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            cyc(); #1;
            check("rh_no_valid", {24'd0, bus.out_valid}, 32'd0);
            check("rh_no_count", {16'd0, bus.sent_count}, 32'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 8'($urandom),
                  3'($urandom), 8'($urandom) | 8'($urandom));
            if ($urandom_range(0, 499) == 0) begin
                #2; rst_n = 1'b0;
                cyc(); rst_n = 1'b1;
            end
        end
        cyc(); bus.in_valid = 1'b0; bus.out_ready = 8'hFF;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
